// File: rtl/scytale_decryption.sv
// rtl/scytale_decryption.sv - scytale (columnar) decryption stage
// Buffers one ciphertext frame until the start token, then emits it column by column.
module scytale_decryption #(
   parameter int D_WIDTH                       = 8,
   parameter int KEY_WIDTH                     = 8,
   parameter int MAX_NOF_CHARS                 = 50,
   parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [D_WIDTH-1:0]   data_i,
   input  logic                 valid_i,
   input  logic [KEY_WIDTH-1:0] key_N,
   input  logic [KEY_WIDTH-1:0] key_M,
   output logic [D_WIDTH-1:0]   data_o,
   output logic                 valid_o,
   output logic                 busy
);

   localparam int CW = $clog2(MAX_NOF_CHARS + 1);
   localparam int LW = 2 * KEY_WIDTH;

   typedef enum logic {IDLE, DECRYPT} state_t;

   state_t               state;
   logic [D_WIDTH-1:0]   buffer [MAX_NOF_CHARS];
   logic [CW-1:0]        count;
   logic [CW-1:0]        idx;
   logic [KEY_WIDTH-1:0] n_r;
   logic [KEY_WIDTH-1:0] m_r;
   logic [KEY_WIDTH-1:0] row;
   logic [KEY_WIDTH-1:0] col;
   logic                 finishing;
   logic [LW-1:0]        frame_len;
   logic                 accept_char;
   logic                 frame_bad;

   assign frame_len   = LW'(n_r) * LW'(m_r);
   assign accept_char = (state == IDLE) && valid_i && (data_i != START_DECRYPTION_TOKEN)
                        && (count < CW'(MAX_NOF_CHARS));
   assign frame_bad   = (count == '0) || (LW'(count) != frame_len);

   always_ff @(posedge clk) begin
      if (accept_char)
         buffer[count] <= data_i;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= '0;
         idx       <= '0;
         n_r       <= '0;
         m_r       <= '0;
         row       <= '0;
         col       <= '0;
         finishing <= 1'b0;
         data_o    <= '0;
         valid_o   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_char)
                  count <= count + 1'b1;
               if (valid_i && data_i == START_DECRYPTION_TOKEN) begin
                  n_r       <= key_N;
                  m_r       <= key_M;
                  row       <= '0;
                  col       <= '0;
                  idx       <= '0;
                  finishing <= 1'b0;
                  busy      <= 1'b1;
                  state     <= DECRYPT;
               end
            end
            DECRYPT: begin
               // First DECRYPT cycle (nothing emitted yet) doubles as the length check.
               if (finishing || (!valid_o && frame_bad)) begin
                  data_o    <= '0;
                  valid_o   <= 1'b0;
                  busy      <= 1'b0;
                  count     <= '0;
                  finishing <= 1'b0;
                  state     <= IDLE;
               end else begin
                  data_o  <= buffer[idx];
                  valid_o <= 1'b1;
                  if (row == n_r - 1'b1) begin
                     row <= '0;
                     col <= col + 1'b1;
                     idx <= CW'(col + 1'b1);
                     if (col == m_r - 1'b1)
                        finishing <= 1'b1;
                  end else begin
                     row <= row + 1'b1;
                     idx <= idx + CW'(m_r);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
